// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: decode-side inputs and EX-side outputs.
// master drives the decode side, slave is the pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
);
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic               RegDst_i;
  logic               Jump_i;
  logic               Branch_i;
  logic               MemRead_i;
  logic               MemToReg_i;
  logic [1:0]         ALUOp_i;
  logic               MemWrite_i;
  logic               ALUSrc_i;
  logic               RegWrite_i;
  logic [DATA_W-1:0]  pc4_i;
  logic [DATA_W-1:0]  rd1_i;
  logic [DATA_W-1:0]  rd2_i;
  logic [DATA_W-1:0]  imm_i;
  logic [RADDR_W-1:0] rs_i;
  logic [RADDR_W-1:0] rt_i;
  logic [RADDR_W-1:0] rd_i;
  logic               RegDst_o;
  logic               Jump_o;
  logic               Branch_o;
  logic               MemRead_o;
  logic               MemToReg_o;
  logic [1:0]         ALUOp_o;
  logic               MemWrite_o;
  logic               ALUSrc_o;
  logic               RegWrite_o;
  logic [DATA_W-1:0]  pc4_o;
  logic [DATA_W-1:0]  rd1_o;
  logic [DATA_W-1:0]  rd2_o;
  logic [DATA_W-1:0]  imm_o;
  logic [RADDR_W-1:0] rs_o;
  logic [RADDR_W-1:0] rt_o;
  logic [RADDR_W-1:0] rd_o;
  logic               ex_valid;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall, flush, id_valid,
    output RegDst_i, Jump_i, Branch_i, MemRead_i, MemToReg_i,
    output ALUOp_i, MemWrite_i, ALUSrc_i, RegWrite_i,
    output pc4_i, rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i,
    input  RegDst_o, Jump_o, Branch_o, MemRead_o, MemToReg_o,
    input  ALUOp_o, MemWrite_o, ALUSrc_o, RegWrite_o,
    input  pc4_o, rd1_o, rd2_o, imm_o, rs_o, rt_o, rd_o,
    input  ex_valid, bubble_cnt
  );

  modport slave (
    input  stall, flush, id_valid,
    input  RegDst_i, Jump_i, Branch_i, MemRead_i, MemToReg_i,
    input  ALUOp_i, MemWrite_i, ALUSrc_i, RegWrite_i,
    input  pc4_i, rd1_i, rd2_i, imm_i, rs_i, rt_i, rd_i,
    output RegDst_o, Jump_o, Branch_o, MemRead_o, MemToReg_o,
    output ALUOp_o, MemWrite_o, ALUSrc_o, RegWrite_o,
    output pc4_o, rd1_o, rd2_o, imm_o, rs_o, rt_o, rd_o,
    output ex_valid, bubble_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, control sanitising
// and a saturating bubble counter.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst,
  id_ex_pipe_reg_if.slave bus
);

  logic               RegDst_q, RegDst_d;
  logic               Jump_q, Jump_d;
  logic               Branch_q, Branch_d;
  logic               MemRead_q, MemRead_d;
  logic               MemToReg_q, MemToReg_d;
  logic [1:0]         ALUOp_q, ALUOp_d;
  logic               MemWrite_q, MemWrite_d;
  logic               ALUSrc_q, ALUSrc_d;
  logic               RegWrite_q, RegWrite_d;
  logic [DATA_W-1:0]  pc4_q, pc4_d;
  logic [DATA_W-1:0]  rd1_q, rd1_d;
  logic [DATA_W-1:0]  rd2_q, rd2_d;
  logic [DATA_W-1:0]  imm_q, imm_d;
  logic [RADDR_W-1:0] rs_q, rs_d;
  logic [RADDR_W-1:0] rt_q, rt_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ctl_en;
  logic               alu_en;

  // an invalid decode slot loads every control as 0
  assign ctl_en  = bus.id_valid;
  assign alu_en  = bus.id_valid & ~bus.Jump_i;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // next state: flush beats stall beats load
  always_comb begin
    RegDst_d   = RegDst_q;
    Jump_d     = Jump_q;
    Branch_d   = Branch_q;
    MemRead_d  = MemRead_q;
    MemToReg_d = MemToReg_q;
    ALUOp_d    = ALUOp_q;
    MemWrite_d = MemWrite_q;
    ALUSrc_d   = ALUSrc_q;
    RegWrite_d = RegWrite_q;
    pc4_d      = pc4_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    if (bus.flush) begin
      RegDst_d   = 1'b0;
      Jump_d     = 1'b0;
      Branch_d   = 1'b0;
      MemRead_d  = 1'b0;
      MemToReg_d = 1'b0;
      ALUOp_d    = 2'b00;
      MemWrite_d = 1'b0;
      ALUSrc_d   = 1'b0;
      RegWrite_d = 1'b0;
      pc4_d      = '0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      valid_d    = 1'b0;
      cnt_d      = cnt_inc;
    end else if (!bus.stall) begin
      RegDst_d   = ctl_en & bus.RegWrite_i & bus.RegDst_i;
      Jump_d     = ctl_en & bus.Jump_i;
      Branch_d   = ctl_en & bus.Branch_i;
      MemRead_d  = ctl_en & bus.MemRead_i;
      MemToReg_d = ctl_en & bus.RegWrite_i & bus.MemToReg_i;
      ALUOp_d    = alu_en ? bus.ALUOp_i : 2'b00;
      MemWrite_d = ctl_en & bus.MemWrite_i;
      ALUSrc_d   = alu_en & bus.ALUSrc_i;
      RegWrite_d = ctl_en & bus.RegWrite_i;
      pc4_d      = bus.pc4_i;
      rd1_d      = bus.rd1_i;
      rd2_d      = bus.rd2_i;
      imm_d      = bus.imm_i;
      rs_d       = bus.rs_i;
      rt_d       = bus.rt_i;
      rd_d       = bus.rd_i;
      valid_d    = bus.id_valid;
      if (!bus.id_valid) cnt_d = cnt_inc;
    end
  end

  // state registers, cleared to a bubble on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegDst_q   <= 1'b0;
      Jump_q     <= 1'b0;
      Branch_q   <= 1'b0;
      MemRead_q  <= 1'b0;
      MemToReg_q <= 1'b0;
      ALUOp_q    <= 2'b00;
      MemWrite_q <= 1'b0;
      ALUSrc_q   <= 1'b0;
      RegWrite_q <= 1'b0;
      pc4_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      RegDst_q   <= RegDst_d;
      Jump_q     <= Jump_d;
      Branch_q   <= Branch_d;
      MemRead_q  <= MemRead_d;
      MemToReg_q <= MemToReg_d;
      ALUOp_q    <= ALUOp_d;
      MemWrite_q <= MemWrite_d;
      ALUSrc_q   <= ALUSrc_d;
      RegWrite_q <= RegWrite_d;
      pc4_q      <= pc4_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.RegDst_o   = RegDst_q;
  assign bus.Jump_o     = Jump_q;
  assign bus.Branch_o   = Branch_q;
  assign bus.MemRead_o  = MemRead_q;
  assign bus.MemToReg_o = MemToReg_q;
  assign bus.ALUOp_o    = ALUOp_q;
  assign bus.MemWrite_o = MemWrite_q;
  assign bus.ALUSrc_o   = ALUSrc_q;
  assign bus.RegWrite_o = RegWrite_q;
  assign bus.pc4_o      = pc4_q;
  assign bus.rd1_o      = rd1_q;
  assign bus.rd2_o      = rd2_q;
  assign bus.imm_o      = imm_q;
  assign bus.rs_o       = rs_q;
  assign bus.rt_o       = rt_q;
  assign bus.rd_o       = rd_q;
  assign bus.ex_valid   = valid_q;
  assign bus.bubble_cnt = cnt_q;

endmodule
